// File: rtl/color_track_multi.sv
// rtl/color_track_multi.sv - multi-channel Cb/Cr window classifier with history filter and per-frame bbox tracking (optional CORNER_TAG_EN)
module color_track_multi #(
   parameter int NUM_CH   = 2,
   parameter int HIST_W   = 4,
   parameter int X_W      = 10,
   parameter int Y_W      = 10,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int CNT_W    = 19,
   localparam int PC_W    = $clog2(NUM_CH + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     vga_vs,
   input  logic                     pix_valid,
   input  logic [X_W-1:0]           pix_x,
   input  logic [Y_W-1:0]           pix_y,
   input  logic [18:0]              pix_addr,
   input  logic [7:0]               cb,
   input  logic [7:0]               cr,
   input  logic [NUM_CH*HIST_W-1:0] hist_rd,
   input  logic [NUM_CH*8-1:0]      cb_lo,
   input  logic [NUM_CH*8-1:0]      cb_hi,
   input  logic [NUM_CH*8-1:0]      cr_lo,
   input  logic [NUM_CH*8-1:0]      cr_hi,
   input  logic [3:0]               hist_thresh,
   output logic [NUM_CH*HIST_W-1:0] hist_wr,
   output logic                     hist_we,
   output logic [18:0]              hist_waddr,
   output logic [PC_W-1:0]          pix_class,
   output logic [NUM_CH*X_W-1:0]    bbox_xmin,
   output logic [NUM_CH*X_W-1:0]    bbox_xmax,
   output logic [NUM_CH*Y_W-1:0]    bbox_ymin,
   output logic [NUM_CH*Y_W-1:0]    bbox_ymax,
   output logic [NUM_CH*CNT_W-1:0]  obj_count,
   output logic [NUM_CH-1:0]        obj_valid,
`ifdef CORNER_TAG_EN
   output logic [2:0]               corner_tag,
`endif
   output logic                     frame_done
);

   localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

   logic                     vs_prev;
   logic                     boundary;
   logic                     in_active;
   logic [4:0]               pc;
   logic [NUM_CH-1:0]        match;
   logic [NUM_CH-1:0]        accept;
   logic [NUM_CH-1:0]        track;
   logic [NUM_CH*HIST_W-1:0] hist_nxt;
   logic [PC_W-1:0]          win_class;

   logic [X_W-1:0]   acc_xmin [NUM_CH];
   logic [X_W-1:0]   acc_xmax [NUM_CH];
   logic [Y_W-1:0]   acc_ymin [NUM_CH];
   logic [Y_W-1:0]   acc_ymax [NUM_CH];
   logic [CNT_W-1:0] acc_cnt  [NUM_CH];

   assign boundary  = vs_prev & ~vga_vs;
   assign in_active = (pix_x <= X_LAST) && (pix_y <= Y_LAST);

   // window match, history gate, next history word and lowest-index winner
   always_comb begin
      pc        = '0;
      match     = '0;
      accept    = '0;
      track     = '0;
      hist_nxt  = '0;
      win_class = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         pc = '0;
         for (int j = 0; j < HIST_W; j++)
            pc = pc + 5'(hist_rd[i*HIST_W + j]);
         match[i] = (cb >= cb_lo[i*8 +: 8]) && (cb <= cb_hi[i*8 +: 8]) &&
                    (cr >= cr_lo[i*8 +: 8]) && (cr <= cr_hi[i*8 +: 8]);
         accept[i] = match[i] && (pc >= {1'b0, hist_thresh});
         // boundary-cycle pixels belong to neither frame
         track[i]  = accept[i] && pix_valid && in_active && !boundary;
         hist_nxt[i*HIST_W +: HIST_W] = {hist_rd[i*HIST_W +: HIST_W-1], match[i]};
         if (accept[i])
            win_class = PC_W'(i + 1);
      end
   end

`ifdef CORNER_TAG_EN
   // x of leftmost/rightmost equals xmin/xmax, so only the other coordinate is kept
   logic [Y_W-1:0] acc_left_y  [NUM_CH];
   logic [Y_W-1:0] acc_right_y [NUM_CH];
   logic [X_W-1:0] acc_top_x   [NUM_CH];
   logic [X_W-1:0] acc_bot_x   [NUM_CH];
   logic [Y_W-1:0] snap_left_y [NUM_CH];
   logic [Y_W-1:0] snap_right_y[NUM_CH];
   logic [X_W-1:0] snap_top_x  [NUM_CH];
   logic [X_W-1:0] snap_bot_x  [NUM_CH];
   logic [2:0]     tag_nxt;

   // compare the pixel with the winning channel's previous-frame extreme points
   always_comb begin
      tag_nxt = 3'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (win_class == PC_W'(i + 1) && obj_valid[i]) begin
            if (pix_x == bbox_xmin[i*X_W +: X_W] && pix_y == snap_left_y[i])
               tag_nxt = 3'd1;
            else if (pix_y == bbox_ymin[i*Y_W +: Y_W] && pix_x == snap_top_x[i])
               tag_nxt = 3'd2;
            else if (pix_y == bbox_ymax[i*Y_W +: Y_W] && pix_x == snap_bot_x[i])
               tag_nxt = 3'd3;
            else if (pix_x == bbox_xmax[i*X_W +: X_W] && pix_y == snap_right_y[i])
               tag_nxt = 3'd4;
         end
      end
   end
`endif

   // per-pixel outputs, frame accumulators and boundary snapshot
   always_ff @(posedge clk) begin
      if (reset) begin
         vs_prev    <= 1'b0;
         hist_we    <= 1'b0;
         hist_wr    <= '0;
         hist_waddr <= '0;
         pix_class  <= '0;
         frame_done <= 1'b0;
         obj_valid  <= '0;
`ifdef CORNER_TAG_EN
         corner_tag <= 3'd0;
`endif
         for (int i = 0; i < NUM_CH; i++) begin
            acc_xmin[i] <= X_LAST;
            acc_xmax[i] <= '0;
            acc_ymin[i] <= Y_LAST;
            acc_ymax[i] <= '0;
            acc_cnt[i]  <= '0;
            bbox_xmin[i*X_W +: X_W]   <= X_LAST;
            bbox_xmax[i*X_W +: X_W]   <= '0;
            bbox_ymin[i*Y_W +: Y_W]   <= Y_LAST;
            bbox_ymax[i*Y_W +: Y_W]   <= '0;
            obj_count[i*CNT_W +: CNT_W] <= '0;
`ifdef CORNER_TAG_EN
            acc_left_y[i]   <= '0;
            acc_right_y[i]  <= '0;
            acc_top_x[i]    <= '0;
            acc_bot_x[i]    <= '0;
            snap_left_y[i]  <= '0;
            snap_right_y[i] <= '0;
            snap_top_x[i]   <= '0;
            snap_bot_x[i]   <= '0;
`endif
         end
      end else begin
         vs_prev    <= vga_vs;
         frame_done <= boundary;
         hist_we    <= pix_valid;
         hist_wr    <= hist_nxt;
         hist_waddr <= pix_addr;
         pix_class  <= pix_valid ? win_class : '0;
`ifdef CORNER_TAG_EN
         corner_tag <= pix_valid ? tag_nxt : 3'd0;
`endif
         for (int i = 0; i < NUM_CH; i++) begin
            if (boundary) begin
               bbox_xmin[i*X_W +: X_W]     <= acc_xmin[i];
               bbox_xmax[i*X_W +: X_W]     <= acc_xmax[i];
               bbox_ymin[i*Y_W +: Y_W]     <= acc_ymin[i];
               bbox_ymax[i*Y_W +: Y_W]     <= acc_ymax[i];
               obj_count[i*CNT_W +: CNT_W] <= acc_cnt[i];
               obj_valid[i] <= (acc_cnt[i] != '0);
               acc_xmin[i]  <= X_LAST;
               acc_xmax[i]  <= '0;
               acc_ymin[i]  <= Y_LAST;
               acc_ymax[i]  <= '0;
               acc_cnt[i]   <= '0;
`ifdef CORNER_TAG_EN
               snap_left_y[i]  <= acc_left_y[i];
               snap_right_y[i] <= acc_right_y[i];
               snap_top_x[i]   <= acc_top_x[i];
               snap_bot_x[i]   <= acc_bot_x[i];
`endif
            end else if (track[i]) begin
               // inclusive compares let ties go to the later pixel
               if (pix_x <= acc_xmin[i]) acc_xmin[i] <= pix_x;
               if (pix_x >= acc_xmax[i]) acc_xmax[i] <= pix_x;
               if (pix_y <= acc_ymin[i]) acc_ymin[i] <= pix_y;
               if (pix_y >= acc_ymax[i]) acc_ymax[i] <= pix_y;
               if (acc_cnt[i] != '1) acc_cnt[i] <= acc_cnt[i] + 1'b1;
`ifdef CORNER_TAG_EN
               if (pix_x <= acc_xmin[i]) acc_left_y[i]  <= pix_y;
               if (pix_x >= acc_xmax[i]) acc_right_y[i] <= pix_y;
               if (pix_y <= acc_ymin[i]) acc_top_x[i]   <= pix_x;
               if (pix_y >= acc_ymax[i]) acc_bot_x[i]   <= pix_x;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_color_track_multi.sv
// tb/tb_color_track_multi.sv - randomized and directed self-checking bench for color_track_multi
module tb_color_track_multi;

   localparam int NC = 2;
   localparam int HW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          vga_vs = 1'b1;
   logic          pix_valid = 1'b0;
   logic [9:0]    pix_x = '0;
   logic [9:0]    pix_y = '0;
   logic [18:0]   pix_addr = '0;
   logic [7:0]    cb = '0;
   logic [7:0]    cr = '0;
   logic [NC*HW-1:0] hist_rd = '0;
   logic [NC*8-1:0]  cb_lo = '0, cb_hi = '0, cr_lo = '0, cr_hi = '0;
   logic [3:0]    hist_thresh = 4'd3;
   logic [NC*HW-1:0] hist_wr;
   logic          hist_we;
   logic [18:0]   hist_waddr;
   logic [1:0]    pix_class;
   logic [NC*10-1:0] bbox_xmin, bbox_xmax;
   logic [NC*10-1:0] bbox_ymin, bbox_ymax;
   logic [NC*19-1:0] obj_count;
   logic [NC-1:0] obj_valid;
   logic          frame_done;

   color_track_multi dut (
      .clk(clk), .reset(reset), .vga_vs(vga_vs), .pix_valid(pix_valid),
      .pix_x(pix_x), .pix_y(pix_y), .pix_addr(pix_addr), .cb(cb), .cr(cr),
      .hist_rd(hist_rd), .cb_lo(cb_lo), .cb_hi(cb_hi), .cr_lo(cr_lo), .cr_hi(cr_hi),
      .hist_thresh(hist_thresh), .hist_wr(hist_wr), .hist_we(hist_we),
      .hist_waddr(hist_waddr), .pix_class(pix_class),
      .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
      .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
      .obj_count(obj_count), .obj_valid(obj_valid), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: accepted pixels of the current frame are simply listed
   typedef struct { int ch; int x; int y; } pt_t;
   pt_t frame_pts[$];
   bit  armed = 0;
   bit  m_vs_prev;
   bit  e_we, e_done;
   int  e_class, e_waddr;
   logic [NC*HW-1:0] e_wr;
   int  s_xmin[NC], s_xmax[NC], s_ymin[NC], s_ymax[NC], s_cnt[NC];
   bit  s_ov[NC];
   bit  bnd, m, ac;
   int  pcnt, n, xmn, xmx, ymn, ymx;
   logic [HW-1:0] h;

   always @(posedge clk) begin
      if (reset) begin
         armed = 1;
         m_vs_prev = 0;
         e_we = 0; e_done = 0; e_class = 0; e_waddr = 0; e_wr = '0;
         frame_pts.delete();
         for (int c = 0; c < NC; c++) begin
            s_xmin[c] = 639; s_xmax[c] = 0; s_ymin[c] = 479; s_ymax[c] = 0;
            s_cnt[c] = 0; s_ov[c] = 0;
         end
      end else begin
         bnd = m_vs_prev && !vga_vs;
         e_we = pix_valid; e_waddr = int'(pix_addr); e_done = bnd; e_class = 0;
         for (int c = 0; c < NC; c++) begin
            h = hist_rd[c*HW +: HW];
            m = (cb >= cb_lo[c*8 +: 8]) && (cb <= cb_hi[c*8 +: 8]) &&
                (cr >= cr_lo[c*8 +: 8]) && (cr <= cr_hi[c*8 +: 8]);
            pcnt = $countones(h);
            ac = m && (pcnt >= int'(hist_thresh));
            e_wr[c*HW +: HW] = {h[HW-2:0], m};
            if (pix_valid && ac && e_class == 0) e_class = c + 1;
            if (pix_valid && ac && !bnd && pix_x < 640 && pix_y < 480)
               frame_pts.push_back('{c, int'(pix_x), int'(pix_y)});
         end
         if (bnd) begin
            for (int c = 0; c < NC; c++) begin
               n = 0; xmn = 639; xmx = 0; ymn = 479; ymx = 0;
               foreach (frame_pts[k]) if (frame_pts[k].ch == c) begin
                  n++;
                  if (frame_pts[k].x < xmn) xmn = frame_pts[k].x;
                  if (frame_pts[k].x > xmx) xmx = frame_pts[k].x;
                  if (frame_pts[k].y < ymn) ymn = frame_pts[k].y;
                  if (frame_pts[k].y > ymx) ymx = frame_pts[k].y;
               end
               s_xmin[c] = xmn; s_xmax[c] = xmx; s_ymin[c] = ymn; s_ymax[c] = ymx;
               s_cnt[c] = n; s_ov[c] = (n != 0);
            end
            frame_pts.delete();
         end
         m_vs_prev = vga_vs;
      end
      #1;
      if (armed) begin
         check("hist_we", hist_we, e_we);
         check("pix_class", pix_class, e_class);
         check("frame_done", frame_done, e_done);
         if (e_we) begin
            check("hist_waddr", hist_waddr, e_waddr);
            check("hist_wr", hist_wr, e_wr);
         end
         for (int c = 0; c < NC; c++) begin
            check($sformatf("xmin%0d", c), bbox_xmin[c*10 +: 10], s_xmin[c]);
            check($sformatf("xmax%0d", c), bbox_xmax[c*10 +: 10], s_xmax[c]);
            check($sformatf("ymin%0d", c), bbox_ymin[c*10 +: 10], s_ymin[c]);
            check($sformatf("ymax%0d", c), bbox_ymax[c*10 +: 10], s_ymax[c]);
            check($sformatf("count%0d", c), obj_count[c*19 +: 19], s_cnt[c]);
            check($sformatf("valid%0d", c), obj_valid[c], s_ov[c]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pix(input int x, input int y, input logic [NC*HW-1:0] hr);
      pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(y); hist_rd = hr;
      pix_addr = 19'($urandom);
      tick();
   endtask

   task automatic set_win(input int c, input int bl, input int bh, input int rl, input int rh);
      cb_lo[c*8 +: 8] = 8'(bl); cb_hi[c*8 +: 8] = 8'(bh);
      cr_lo[c*8 +: 8] = 8'(rl); cr_hi[c*8 +: 8] = 8'(rh);
   endtask

   int lo;

   initial begin
      set_win(0, 0, 100, 0, 100);
      set_win(1, 200, 255, 200, 255);
      tick(); tick();
      check("rst_we", hist_we, 0);
      check("rst_xmin0", bbox_xmin[9:0], 639);
      check("rst_ymin0", bbox_ymin[9:0], 479);
      check("rst_valid", obj_valid, 0);
      reset = 1'b0;
      tick();

      // accepted pixel, then history too weak
      cb = 8'd50; cr = 8'd50;
      pix_valid = 1'b1; pix_x = 10'd10; pix_y = 10'd20; hist_rd = 8'h0F; pix_addr = 19'h12345;
      tick();
      check("t1_class", pix_class, 1);
      check("t1_we", hist_we, 1);
      check("t1_wr", hist_wr[3:0], 4'b1111);
      check("t1_addr", hist_waddr, 19'h12345);
      pix(10, 20, 8'h03);
      check("t2_class", pix_class, 0);
      check("t2_wr", hist_wr[3:0], 4'b0111);

      // box over a frame; out-of-range column ignored
      pix(300, 5, 8'h0F);
      pix(639, 479, 8'h0F);
      pix(640, 100, 8'h0F);
      pix_valid = 1'b0; vga_vs = 1'b0;
      tick();
      check("t3_done", frame_done, 1);
      check("t3_xmin", bbox_xmin[9:0], 10);
      check("t3_xmax", bbox_xmax[9:0], 639);
      check("t3_ymin", bbox_ymin[9:0], 5);
      check("t3_ymax", bbox_ymax[9:0], 479);
      check("t3_cnt", obj_count[18:0], 3);
      check("t3_valid", obj_valid, 2'b01);
      tick();
      check("t3_done_low", frame_done, 0);

      // overlapping windows: lowest index wins, both count
      vga_vs = 1'b1;
      set_win(1, 0, 255, 0, 255);
      pix(5, 5, 8'hFF);
      check("t4_class", pix_class, 1);
      set_win(1, 200, 255, 200, 255);
      pix_valid = 1'b0; vga_vs = 1'b0;
      tick();
      check("t4_cnt0", obj_count[18:0], 1);
      check("t4_cnt1", obj_count[37:19], 1);

      // ch1 empty; pixel in boundary cycle counted nowhere
      vga_vs = 1'b1;
      pix(50, 60, 8'h0F);
      vga_vs = 1'b0;
      pix(1, 1, 8'h0F);
      check("t5_bnd_we", hist_we, 1);
      check("t5_bnd_class", pix_class, 1);
      check("t5_cnt0", obj_count[18:0], 1);
      check("t5_valid", obj_valid, 2'b01);
      check("t5_xmin1", bbox_xmin[19:10], 639);
      check("t5_xmax1", bbox_xmax[19:10], 0);
      pix_valid = 1'b0; vga_vs = 1'b1;
      tick();
      vga_vs = 1'b0;
      tick();
      check("t5_next_cnt0", obj_count[18:0], 0);
      check("t5_next_valid", obj_valid, 2'b00);

      // threshold above history width never accepts
      vga_vs = 1'b1; hist_thresh = 4'd5;
      pix(20, 20, 8'hFF);
      check("t6_thresh", pix_class, 0);
      hist_thresh = 4'd3;

      // reset mid-frame drops earlier pixels
      pix(30, 30, 8'h0F);
      pix_valid = 1'b0; reset = 1'b1;
      tick();
      check("t7_rst_valid", obj_valid, 0);
      reset = 1'b0;
      pix(70, 80, 8'h0F);
      pix_valid = 1'b0; vga_vs = 1'b0;
      tick();
      check("t7_cnt0", obj_count[18:0], 1);
      check("t7_xmin0", bbox_xmin[9:0], 70);
      vga_vs = 1'b1;

      // randomized traffic
      for (int it = 0; it < 4000; it++) begin
         if (it % 250 == 0) begin
            for (int c = 0; c < NC; c++) begin
               lo = $urandom_range(0, 200);
               cb_lo[c*8 +: 8] = 8'(lo);
               cb_hi[c*8 +: 8] = 8'((lo + $urandom_range(0, 120)) > 255 ? 255 : lo + $urandom_range(0, 120));
               lo = $urandom_range(0, 200);
               cr_lo[c*8 +: 8] = 8'(lo);
               cr_hi[c*8 +: 8] = 8'((lo + $urandom_range(0, 120)) > 255 ? 255 : lo + $urandom_range(0, 120));
            end
         end
         reset = ($urandom_range(0, 1499) == 0);
         if ($urandom_range(0, 199) == 0) vga_vs = 1'b0;
         else if (!vga_vs && $urandom_range(0, 3) == 0) vga_vs = 1'b1;
         pix_valid = ($urandom_range(0, 4) != 0);
         pix_x = 10'($urandom_range(0, 700));
         pix_y = 10'($urandom_range(0, 520));
         pix_addr = 19'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            lo = $urandom_range(0, NC - 1);
            cb = 8'($urandom_range(int'(cb_lo[lo*8 +: 8]), int'(cb_hi[lo*8 +: 8])));
            cr = 8'($urandom_range(int'(cr_lo[lo*8 +: 8]), int'(cr_hi[lo*8 +: 8])));
         end else begin
            cb = 8'($urandom); cr = 8'($urandom);
         end
         hist_rd = NC*HW'($urandom);
         hist_thresh = 4'($urandom_range(0, 5));
         tick();
      end
      reset = 1'b0; pix_valid = 1'b0;
      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
